// File: rtl/cpu_pkg.sv
// Shared types and instruction-encoding constants for the multicycle CPU.
package cpu_pkg;

    // Control FSM states
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    // ALU operations
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    localparam int unsigned IR_W = 32;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/alu_param.sv
// Combinational ALU: add, sub, and, or, signed set-less-than.
module alu_param
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] y_c
);

    // Operation select
    always_comb begin
        y_c = '0;
        case (op_i)
            ALU_ADD: y_c = a_i + b_i;
            ALU_SUB: y_c = a_i - b_i;
            ALU_AND: y_c = a_i & b_i;
            ALU_OR:  y_c = a_i | b_i;
            ALU_SLT: y_c = DATA_W'($signed(a_i) < $signed(b_i));
            default: y_c = '0;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle RV32I-subset CPU with handshaked instruction and data ports.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IR_W-1:0]   imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic              trap,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              trap_q, trap_d, retire_q, retire_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

    // Instruction fields
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd_idx, rs1_idx, rs2_idx;
    logic signed [31:0] imm_i, imm_s, imm_b;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign f7      = ir_q[31:25];
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    logic    is_r, is_addi, is_lw, is_sw, is_beq, legal, regs_bad;
    alu_op_e r_op;

    // R-type decode: only the five supported funct7/funct3 pairs are legal
    always_comb begin
        is_r = 1'b0;
        r_op = ALU_ADD;
        if (opcode == OPC_OP) begin
            if (f7 == F7_SUB && f3 == F3_ADD) begin
                is_r = 1'b1;
                r_op = ALU_SUB;
            end else if (f7 == F7_BASE) begin
                case (f3)
                    F3_ADD:  begin is_r = 1'b1; r_op = ALU_ADD; end
                    F3_SLT:  begin is_r = 1'b1; r_op = ALU_SLT; end
                    F3_OR:   begin is_r = 1'b1; r_op = ALU_OR;  end
                    F3_AND:  begin is_r = 1'b1; r_op = ALU_AND; end
                    default: is_r = 1'b0;
                endcase
            end
        end
    end

    assign is_addi = (opcode == OPC_OPIMM)  && (f3 == F3_ADD);
    assign is_lw   = (opcode == OPC_LOAD)   && (f3 == F3_WORD);
    assign is_sw   = (opcode == OPC_STORE)  && (f3 == F3_WORD);
    assign is_beq  = (opcode == OPC_BRANCH) && (f3 == F3_BEQ);
    assign legal   = is_r | is_addi | is_lw | is_sw | is_beq;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    // Any register index the instruction actually uses must exist
    assign regs_bad = !idx_ok(rs1_idx)
                    || ((is_r | is_sw | is_beq) && !idx_ok(rs2_idx))
                    || ((is_r | is_addi | is_lw) && !idx_ok(rd_idx));

    logic [DATA_W-1:0] alu_y;
    logic [ADDR_W-1:0] mem_addr, pc_plus4;

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .a_i  (opa_q),
        .b_i  (is_r ? opb_q : DATA_W'(imm_i)),
        .op_i (is_r ? r_op : ALU_ADD),
        .y_c  (alu_y)
    );

    assign mem_addr = ADDR_W'(opa_q) + ADDR_W'(is_sw ? imm_s : imm_i);
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Next-state and datapath updates
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        res_d        = res_q;
        regs_d       = regs_q;
        trap_d       = trap_q;
        retire_d     = 1'b0;
        imem_req_d   = imem_req_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        case (state_q)
            S_FETCH: begin
                if (!imem_req_q) begin
                    imem_req_d = 1'b1;
                end else if (imem_ready) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                opa_d = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx[RIDX_W-1:0]];
                opb_d = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx[RIDX_W-1:0]];
                if (!legal || regs_bad) begin
                    trap_d  = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_d       = (opa_q == opb_q) ? pc_q + ADDR_W'(imm_b) : pc_plus4;
                    retire_d   = 1'b1;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_lw || is_sw) begin
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_sw;
                    dmem_addr_d  = mem_addr;
                    dmem_wdata_d = opb_q;
                    state_d      = S_MEM;
                end else begin
                    res_d   = alu_y;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_req_q && dmem_ready) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (is_sw) begin
                        pc_d       = pc_plus4;
                        retire_d   = 1'b1;
                        imem_req_d = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (rd_idx != 5'd0) begin
                    regs_d[rd_idx[RIDX_W-1:0]] = res_q;
                end
                pc_d       = pc_plus4;
                retire_d   = 1'b1;
                imem_req_d = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap_d     = 1'b1;
                imem_req_d = 1'b0;
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            res_q        <= '0;
            regs_q       <= '{default: '0};
            trap_q       <= 1'b0;
            retire_q     <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            res_q        <= res_d;
            regs_q       <= regs_d;
            trap_q       <= trap_d;
            retire_q     <= retire_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign retire     = retire_q;
    assign trap       = trap_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed self-checking bench for cpu_multicycle (DATA_W=8, ADDR_W=8, NREGS=8).
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, trap;
    logic [7:0]  pc;

    cpu_multicycle #(.DATA_W(8), .ADDR_W(8), .NREGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .retire     (retire),
        .trap       (trap),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // Memories: zero-wait instruction memory, data memory with programmable wait
    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    logic [7:0]  wr_addr [64];
    logic [7:0]  wr_data [64];
    int          dly = 0;
    int          dcnt = 0;
    int          n_wr = 0;
    int          cyc = 0;
    logic        fill_en = 1'b0;

    assign imem_ready = 1'b1;
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ready = dmem_req && (dcnt == dly);

    // Data memory write port, wait counter and cycle counter
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'hAA;
        end else if (dmem_req && dmem_ready && dmem_we) begin
            dmem[dmem_addr]     <= dmem_wdata;
            wr_addr[n_wr & 63]  <= dmem_addr;
            wr_data[n_wr & 63]  <= dmem_wdata;
            n_wr                <= n_wr + 1;
        end
        if (rst || !dmem_req || dmem_ready) dcnt <= 0;
        else                                dcnt <= dcnt + 1;
        cyc <= cyc + 1;
    end

    // Retire log and data-request stability monitor
    int         n_ret = 0;
    int         ret_cyc [256];
    logic [7:0] ret_pc [256];
    int         run = 0;
    int         runs [64];
    int         n_runs = 0;
    int         stab_err = 0;
    logic [7:0] r_addr, r_wd;
    logic       r_we;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else begin
            if (retire) begin
                ret_cyc[n_ret & 255] = cyc;
                ret_pc[n_ret & 255]  = pc;
                n_ret++;
            end
            if (dmem_req) begin
                if (run == 0) begin
                    r_addr = dmem_addr;
                    r_we   = dmem_we;
                    r_wd   = dmem_wdata;
                end else if (dmem_addr !== r_addr || dmem_we !== r_we || dmem_wdata !== r_wd) begin
                    stab_err++;
                end
                run++;
            end else if (run != 0) begin
                runs[n_runs & 63] = run;
                n_runs++;
                run = 0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int req_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_sw(input int rs2, input int imm, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_beq(input int rs1, input int rs2, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'h13);
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    // Reset for two cycles, check idle outputs, release and check the first fetch
    task automatic do_reset(input string tag);
        rst = 1'b1;
        fill_en = 1'b1;
        tick();
        fill_en = 1'b0;
        tick();
        check_eq({tag, "_rst_imem_req"}, 32'(imem_req), 0);
        check_eq({tag, "_rst_dmem_req"}, 32'(dmem_req), 0);
        check_eq({tag, "_rst_dmem_we"},  32'(dmem_we), 0);
        check_eq({tag, "_rst_retire"},   32'(retire), 0);
        check_eq({tag, "_rst_trap"},     32'(trap), 0);
        check_eq({tag, "_rst_pc"},       32'(pc), 0);
        rst = 1'b0;
        tick();
        check_eq({tag, "_rel_imem_req"},  32'(imem_req), 1);
        check_eq({tag, "_rel_imem_addr"}, 32'(imem_addr), 0);
        check_eq({tag, "_rel_retire"},    32'(retire), 0);
        check_eq({tag, "_rel_trap"},      32'(trap), 0);
        req_cyc = cyc;
    endtask

    task automatic wait_ret(input int target, input int budget, input string tag);
        int k = 0;
        while (n_ret < target && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, n_ret, target);
    endtask

    task automatic wait_trap(input int budget, input string tag);
        int k = 0;
        while (!trap && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(trap), 1);
    endtask

    initial begin
        int b, wb, rb, busy;

        // Arithmetic, x0 writes, logic ops, signed slt
        clear_imem();
        imem[0]  = addi(1, 0, -3);
        imem[1]  = addi(2, 0, 5);
        imem[2]  = enc_r(0, 2, 1, 2, 3);
        imem[3]  = enc_r(32, 1, 2, 0, 4);
        imem[4]  = addi(0, 0, 7);
        imem[5]  = enc_r(0, 2, 1, 7, 5);
        imem[6]  = enc_r(0, 2, 1, 6, 6);
        imem[7]  = enc_r(0, 1, 2, 2, 7);
        imem[8]  = enc_sw(1, 0, 0);
        imem[9]  = enc_sw(2, 1, 0);
        imem[10] = enc_sw(3, 2, 0);
        imem[11] = enc_sw(4, 3, 0);
        imem[12] = enc_sw(0, 5, 0);
        imem[13] = enc_sw(5, 6, 0);
        imem[14] = enc_sw(6, 7, 0);
        imem[15] = enc_sw(7, 9, 0);
        dly = 0;
        b = n_ret;
        do_reset("arith");
        wait_ret(b + 16, 300, "arith_retires");
        check_eq("arith_4instr_cycles", ret_cyc[(b + 3) & 255] - req_cyc, 16);
        check_eq("arith_addi_cycles",   ret_cyc[b & 255] - req_cyc, 4);
        check_eq("arith_x1", 32'(dmem[0]), 32'hFD);
        check_eq("arith_x2", 32'(dmem[1]), 32'h05);
        check_eq("arith_x3_slt", 32'(dmem[2]), 32'h01);
        check_eq("arith_x4_sub", 32'(dmem[3]), 32'h08);
        check_eq("arith_x0_zero", 32'(dmem[5]), 32'h00);
        check_eq("arith_x5_and", 32'(dmem[6]), 32'h05);
        check_eq("arith_x6_or", 32'(dmem[7]), 32'hFD);
        check_eq("arith_x7_slt_rev", 32'(dmem[9]), 32'h00);
        check_eq("arith_sw_cycles", ret_cyc[(b + 9) & 255] - ret_cyc[(b + 8) & 255], 4);
        wait_trap(20, "arith_end_trap");
        check_eq("arith_end_pc", 32'(pc), 32'h40);

        // Stores and loads with a two-cycle data wait
        clear_imem();
        imem[0] = addi(2, 0, 5);
        imem[1] = enc_sw(2, 4, 0);
        imem[2] = enc_i(4, 0, 2, 5, 7'h03);
        imem[3] = enc_sw(5, 8, 0);
        dly = 2;
        do_reset("mem");
        b  = n_ret;
        wb = n_wr;
        rb = n_runs;
        wait_ret(b + 4, 200, "mem_retires");
        check_eq("mem_wr_addr", 32'(wr_addr[wb & 63]), 4);
        check_eq("mem_wr_data", 32'(wr_data[wb & 63]), 5);
        check_eq("mem_lw_x5", 32'(dmem[8]), 5);
        check_eq("mem_sw_req_len", runs[rb & 63], 3);
        check_eq("mem_lw_req_len", runs[(rb + 1) & 63], 3);
        check_eq("mem_sw_cycles", ret_cyc[(b + 1) & 255] - ret_cyc[b & 255], 6);
        check_eq("mem_lw_cycles", ret_cyc[(b + 2) & 255] - ret_cyc[(b + 1) & 255], 7);

        // Branches: negative taken with wrap, +4 wrap, not taken, forward taken
        clear_imem();
        imem[0]  = enc_beq(1, 0, -4);
        imem[63] = addi(1, 0, 1);
        imem[1]  = enc_beq(0, 0, 8);
        dly = 0;
        do_reset("br");
        b = n_ret;
        wait_ret(b + 4, 200, "br_retires");
        check_eq("br_taken_wrap_pc", 32'(ret_pc[b & 255]), 32'hFC);
        check_eq("br_beq_cycles", ret_cyc[b & 255] - req_cyc, 3);
        check_eq("br_pc4_wrap_pc", 32'(ret_pc[(b + 1) & 255]), 32'h00);
        check_eq("br_not_taken_pc", 32'(ret_pc[(b + 2) & 255]), 32'h04);
        check_eq("br_fwd_taken_pc", 32'(ret_pc[(b + 3) & 255]), 32'h0C);
        check_eq("br_nt_cycles", ret_cyc[(b + 2) & 255] - ret_cyc[(b + 1) & 255], 3);
        wait_trap(20, "br_end_trap");

        // Illegal opcode traps after decode and stays quiet
        clear_imem();
        imem[0] = addi(1, 0, 1);
        imem[1] = 32'h0000007F;
        do_reset("ill");
        b = n_ret;
        wait_ret(b + 1, 50, "ill_retire");
        wait_trap(20, "ill_trap");
        check_eq("ill_pc", 32'(pc), 4);
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (imem_req || dmem_req || retire) busy++;
        end
        check_eq("ill_quiet", busy, 0);
        check_eq("ill_trap_sticky", 32'(trap), 1);
        check_eq("ill_pc_frozen", 32'(pc), 4);

        // Destination register beyond NREGS traps; reset recovers first
        clear_imem();
        imem[0] = addi(9, 0, 1);
        do_reset("rd9");
        b = n_ret;
        wait_trap(20, "rd9_trap");
        check_eq("rd9_pc", 32'(pc), 0);
        check_eq("rd9_no_retire", n_ret - b, 0);

        // Reset in the middle of a data handshake abandons it
        clear_imem();
        imem[0] = addi(2, 0, 5);
        imem[1] = enc_sw(2, 4, 0);
        dly = 6;
        do_reset("abort");
        busy = 0;
        while (!dmem_req && busy < 50) begin
            tick();
            busy++;
        end
        check_eq("abort_req_seen", 32'(dmem_req), 1);
        tick();
        wb = n_wr;
        rst = 1'b1;
        tick();
        check_eq("abort_dmem_req", 32'(dmem_req), 0);
        check_eq("abort_dmem_we", 32'(dmem_we), 0);
        check_eq("abort_pc", 32'(pc), 0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("abort_no_write", n_wr - wb, 0);
        check_eq("abort_mem_kept", 32'(dmem[4]), 32'hAA);

        check_eq("dmem_req_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: register, ALU and data-port width.
REQ-002 The block SHALL have parameter ADDR_W, default 8: PC and address width.
REQ-003 The block SHALL have parameter NREGS, default 8: architectural registers, power of two, 2..32.
REQ-004 The block SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port imem_req  out  1  instruction fetch request.
REQ-007 The block SHALL have port imem_addr  out  ADDR_W  fetch address (= PC).
REQ-008 The block SHALL have port imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-009 The block SHALL have port imem_ready  in  1  fetch complete.
REQ-010 The block SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out ADDR_W, dmem_wdata out DATA_W: data access request, write enable, address, store data.
REQ-011 The block SHALL have ports dmem_rdata in DATA_W and dmem_ready in 1: load data and access complete.
REQ-012 The block SHALL have ports retire out 1 (one-cycle pulse per completed instruction), trap out 1 (sticky illegal-instruction flag) and pc out ADDR_W.

Function
REQ-013 The block SHALL execute add, sub, and, or, slt (op 0110011), addi (0010011/f3 000), lw (0000011/f3 010), sw (0100011/f3 010) and beq (1100011/f3 000); every other encoding is illegal.
REQ-014 The FSM SHALL use states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-015 FETCH: hold imem_req=1 with imem_addr=PC until imem_ready=1; latch IR; go to DECODE.
REQ-016 DECODE: read rs1/rs2 into operand registers; go to TRAP if the encoding is illegal or any used register index >= NREGS, else to EXEC.
REQ-017 EXEC: compute the ALU result or address; R/addi -> WB; lw/sw -> MEM; beq -> PC update, retire, FETCH.
REQ-018 MEM: hold dmem_req=1, dmem_addr=rs1+imm (low ADDR_W bits), dmem_we=1 for sw, until dmem_ready=1; sw -> PC+4, retire, FETCH; lw -> latch dmem_rdata, WB.
REQ-019 WB: write the result to rd unless rd=0; PC += 4; retire=1; go to FETCH.
REQ-020 Register x0 SHALL read as 0 at all times.
REQ-021 Immediates SHALL be sign-extended from 12 bits (I/S) or 13 bits (B) and then truncated to DATA_W/ADDR_W; all arithmetic is modulo 2^width.
REQ-022 slt SHALL compare signed DATA_W values.
REQ-023 A taken beq SHALL set PC := PC + Bimm; otherwise PC := PC + 4; both modulo 2^ADDR_W.
REQ-024 Minimum cycles with zero-wait memory SHALL be: R/addi 4, lw 5, sw 4, beq 3; each wait cycle adds one.
REQ-025 TRAP SHALL be terminal: trap=1, no requests, PC frozen at the faulting instruction; exit only by reset.
REQ-026 imem_ready/dmem_ready while the corresponding req=0 SHALL be ignored.
REQ-027 Request outputs SHALL be registered-stable: address and data do not change while req=1.

Reset
REQ-028 rst=1 at a clock edge SHALL force state FETCH, PC=0, IR=0, all registers 0, trap=0, retire=0, imem_req=0, dmem_req=0 and dmem_we=0.
REQ-029 imem_req SHALL assert on the first cycle after rst deasserts.
REQ-030 Reset during an outstanding handshake SHALL abandon it; a ready arriving afterwards SHALL be ignored, and no register or PC update SHALL occur.

Structure
REQ-031 Package cpu_pkg SHALL hold the state enum, opcode/funct3/funct7 constants and the ALU-operation enum.
REQ-032 Sub-module alu_param SHALL be combinational, parameterised by DATA_W, and implement ADD/SUB/AND/OR/SLT.
REQ-033 The register file SHALL be internal to cpu_multicycle.

Verification
REQ-034 Reset check: release rst with zero-wait memories -> imem_req=1 and imem_addr=0 next cycle; retire=0 and trap=0.
REQ-035 Arithmetic: addi x1,x0,-3; addi x2,x0,5; slt x3,x1,x2; sub x4,x2,x1 (DATA_W=8) -> x1=0xFD, x2=0x05, x3=1, x4=0x08; 4 retire pulses, 16 cycles.
REQ-036 Memory with 2-cycle dmem_ready delay: sw x2,4(x0) then lw x5,4(x0) -> a write to addr 4 with data 0x05, then x5=0x05; dmem_req is held stable for 3 cycles each.
REQ-037 Branch and wrap: beq x0,x0,-4 at PC=0 -> PC=0xFC (ADDR_W=8); a not-taken beq -> PC+4.
REQ-038 Illegal and boundary cases: opcode 0x7F, or rd=9 with NREGS=8 -> trap=1 after DECODE, no further imem_req; rst then recovers to PC=0.
REQ-039 Writes to x0: addi x0,x0,7 -> x0 still reads 0 and retire still pulses.
